// File: rtl/timer_cnt_core.sv
// -----------------------------------------------------------------------------
// timer_cnt_core
//
// Counting engine of the APB timer. Takes the decoded timer register fields
// from the register bank and produces the live 64-bit count, the sticky
// interrupt status, the registered interrupt pin and the debug halt
// acknowledge.
//
// Ports
//   sys_clk    in   1  system clock, all state updates on the rising edge
//   sys_rst_n  in   1  asynchronous active-low reset
//   tim_en     in   1  TCR.timer_en
//   div_en     in   1  TCR.div_en
//   div_val    in   4  TCR.div_val (9..15 behave as 8)
//   dbg_mode   in   1  system debug-mode indication
//   halt_req   in   1  THCSR.halt_req
//   tdr0_wr    in   1  one-cycle strobe, loads cnt[31:0] from wdata
//   tdr1_wr    in   1  one-cycle strobe, loads cnt[63:32] from wdata
//   wdata      in  32  APB write data
//   tcmp       in  64  {TCMP1, TCMP0}
//   int_en     in   1  TIER.int_en
//   int_clr    in   1  one-cycle strobe from a write of 1 to TISR bit 0
//   cnt        out 64  {TDR1, TDR0} readback
//   int_st     out  1  TISR bit 0 (sticky compare-match flag)
//   tim_int    out  1  interrupt pin, registered int_st & int_en
//   halt_ack   out  1  THCSR.halt_ack, registered halt_req & dbg_mode
//
// Handshake note: there is no valid/ready pairing on this block. Every input
// is sampled on each rising edge; the strobes (tdr0_wr, tdr1_wr, int_clr) act
// once per cycle they are high, and every output is a register that changes
// only on a rising edge or on reset.
// -----------------------------------------------------------------------------
module timer_cnt_core (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tim_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        dbg_mode,
    input  logic        halt_req,
    input  logic        tdr0_wr,
    input  logic        tdr1_wr,
    input  logic [31:0] wdata,
    input  logic [63:0] tcmp,
    input  logic        int_en,
    input  logic        int_clr,
    output logic [63:0] cnt,
    output logic        int_st,
    output logic        tim_int,
    output logic        halt_ack
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [63:0] cnt_q,      cnt_d;
    logic [7:0]  pre_q,      pre_d;
    logic        int_st_q,   int_st_d;
    logic        tim_int_q,  tim_int_d;
    logic        halt_ack_q, halt_ack_d;
    logic        tim_en_q,   tim_en_d;
    logic [4:0]  div_cfg_q,  div_cfg_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [7:0]  div_limit;
    logic [4:0]  div_cfg;
    logic        div_cfg_chg;
    logic        act;
    logic        cnt_en;
    logic        tim_en_fall;
    logic        tdr_wr;
    logic        match;

    // Terminal value of the prescaler. The divide ratio is div_limit + 1,
    // i.e. 2^div_val, saturating at 256 for div_val >= 8.
    always_comb begin
        div_limit = 8'h00;
        if (div_en) begin
            case (div_val)
                4'd0:    div_limit = 8'h00;
                4'd1:    div_limit = 8'h01;
                4'd2:    div_limit = 8'h03;
                4'd3:    div_limit = 8'h07;
                4'd4:    div_limit = 8'h0F;
                4'd5:    div_limit = 8'h1F;
                4'd6:    div_limit = 8'h3F;
                4'd7:    div_limit = 8'h7F;
                default: div_limit = 8'hFF;
            endcase
        end
    end

    // A change of the divider setting restarts the prescaler so the first
    // period at the new ratio is a full one. The comparison is against the
    // setting seen last cycle, so the restart lands in the following cycle.
    assign div_cfg     = {div_en, div_val};
    assign div_cfg_chg = (div_cfg != div_cfg_q);

    // The registered halt_ack (not the raw request) gates counting, so
    // freeze and resume line up exactly with what software reads back.
    assign act         = tim_en & ~halt_ack_q;
    assign cnt_en      = act & (pre_q == div_limit);

    assign tim_en_fall = tim_en_q & ~tim_en;
    assign tdr_wr      = tdr0_wr | tdr1_wr;

    // Level compare on the registered count, independent of enables.
    assign match       = (cnt_q == tcmp);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pre_d = pre_q;
        if (!tim_en || div_cfg_chg) begin
            pre_d = 8'h00;
        end else if (act) begin
            if (pre_q == div_limit) begin
                pre_d = 8'h00;
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end
    end

    // Register writes beat the disable clear, which beats counting. The word
    // not addressed by a strobe keeps its current value.
    always_comb begin
        cnt_d = cnt_q;
        if (tdr_wr) begin
            if (tdr0_wr) begin
                cnt_d[31:0] = wdata;
            end
            if (tdr1_wr) begin
                cnt_d[63:32] = wdata;
            end
        end else if (tim_en_fall) begin
            cnt_d = 64'd0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    // Set dominates clear: a clear issued while the compare still holds is
    // lost, the flag only drops once cnt has moved off tcmp.
    always_comb begin
        int_st_d = int_st_q;
        if (match) begin
            int_st_d = 1'b1;
        end else if (int_clr) begin
            int_st_d = 1'b0;
        end
    end

    always_comb begin
        tim_int_d  = int_st_q & int_en;
        halt_ack_d = halt_req & dbg_mode;
        tim_en_d   = tim_en;
        div_cfg_d  = div_cfg;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= 64'd0;
            pre_q      <= 8'h00;
            int_st_q   <= 1'b0;
            tim_int_q  <= 1'b0;
            halt_ack_q <= 1'b0;
            tim_en_q   <= 1'b0;
            div_cfg_q  <= 5'd0;
        end else begin
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            int_st_q   <= int_st_d;
            tim_int_q  <= tim_int_d;
            halt_ack_q <= halt_ack_d;
            tim_en_q   <= tim_en_d;
            div_cfg_q  <= div_cfg_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cnt      = cnt_q;
    assign int_st   = int_st_q;
    assign tim_int  = tim_int_q;
    assign halt_ack = halt_ack_q;

endmodule

// File: tb/tb_timer_cnt_core.sv
// -----------------------------------------------------------------------------
// Bench for timer_cnt_core. A reference model of the timer rules runs on every
// rising edge and pushes the expected {cnt, int_st, tim_int, halt_ack} into a
// queue; a monitor on the falling edge pops and compares. Directed sequences
// additionally check the timing points called out for the timer.
// -----------------------------------------------------------------------------
module tb_timer_cnt_core;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        tim_en, div_en, dbg_mode, halt_req;
    logic [3:0]  div_val;
    logic        tdr0_wr, tdr1_wr, int_en, int_clr;
    logic [31:0] wdata;
    logic [63:0] tcmp;
    logic [63:0] cnt;
    logic        int_st, tim_int, halt_ack;

    timer_cnt_core dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .tim_en   (tim_en),
        .div_en   (div_en),
        .div_val  (div_val),
        .dbg_mode (dbg_mode),
        .halt_req (halt_req),
        .tdr0_wr  (tdr0_wr),
        .tdr1_wr  (tdr1_wr),
        .wdata    (wdata),
        .tcmp     (tcmp),
        .int_en   (int_en),
        .int_clr  (int_clr),
        .cnt      (cnt),
        .int_st   (int_st),
        .tim_int  (tim_int),
        .halt_ack (halt_ack)
    );

    // ---------------------------------------------------------------- clock
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within 200us");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- scoreboard
    logic [66:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [66:0] mon_exp;
    logic [66:0] mon_got;

    always @(negedge sys_clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {cnt, int_st, tim_int, halt_ack};
            tests++;
            if (mon_got !== mon_exp) begin
                fails++;
                $display("FAIL sb cyc=%0d got cnt=%h int_st=%b tim_int=%b halt_ack=%b want cnt=%h int_st=%b tim_int=%b halt_ack=%b",
                         cyc, mon_got[66:3], mon_got[2], mon_got[1], mon_got[0],
                         mon_exp[66:3], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Timer rules in plain terms: the count advances once per divide period
    // of D = 2^min(div_val,8) active cycles (D = 1 when undivided); m_phase is
    // how many active cycles of the current period have elapsed.
    logic [63:0] m_cnt;
    bit          m_int_st, m_tim_int, m_halt, m_prev_en;
    logic [4:0]  m_prev_cfg;
    int          m_phase;

    function automatic int div_period(input logic en, input logic [3:0] v);
        int e;
        if (!en || v == 4'd0) return 1;
        e = (v > 4'd8) ? 8 : int'(v);
        return 1 << e;
    endfunction

    task automatic model_reset();
        m_cnt      = 64'd0;
        m_int_st   = 1'b0;
        m_tim_int  = 1'b0;
        m_halt     = 1'b0;
        m_prev_en  = 1'b0;
        m_prev_cfg = 5'd0;
        m_phase    = 0;
    endtask

    task automatic model_step();
        int         d;
        bit         active, tick;
        logic [4:0] cfg;
        if (!sys_rst_n) begin
            model_reset();
        end else begin
            d      = div_period(div_en, div_val);
            cfg    = {div_en, div_val};
            active = tim_en && !m_halt;
            tick   = active && (m_phase == d - 1);
            m_tim_int = m_int_st && int_en;
            if (m_cnt == tcmp)  m_int_st = 1'b1;
            else if (int_clr)   m_int_st = 1'b0;
            if (tdr0_wr || tdr1_wr) begin
                if (tdr0_wr) m_cnt[31:0]  = wdata;
                if (tdr1_wr) m_cnt[63:32] = wdata;
            end else if (m_prev_en && !tim_en) begin
                m_cnt = 64'd0;
            end else if (tick) begin
                m_cnt = m_cnt + 64'd1;
            end
            if (!tim_en || cfg != m_prev_cfg) m_phase = 0;
            else if (active)                  m_phase = tick ? 0 : m_phase + 1;
            m_halt     = halt_req && dbg_mode;
            m_prev_en  = tim_en;
            m_prev_cfg = cfg;
        end
        exp_q.push_back({m_cnt, m_int_st, m_tim_int, m_halt});
    endtask

    // ---------------------------------------------------------------- driver
    task automatic step();
        @(posedge sys_clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic load_cnt(input logic [63:0] v);
        wdata   = v[31:0];
        tdr0_wr = 1'b1;
        step();
        tdr0_wr = 1'b0;
        wdata   = v[63:32];
        tdr1_wr = 1'b1;
        step();
        tdr1_wr = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    int          c0, rel, first_is, first_ti, first_ack;
    logic [63:0] cnt_a, cnt_b, cnt_c, cnt_d, cnt_e;
    logic [63:0] wc [0:5];
    logic        wi [0:5];

    initial begin
        sys_rst_n = 1'b0;
        tim_en = 1'b1; div_en = 1'b0; div_val = 4'd0; dbg_mode = 1'b1; halt_req = 1'b1;
        tdr0_wr = 1'b0; tdr1_wr = 1'b0; wdata = 32'h0; tcmp = 64'd0;
        int_en = 1'b1; int_clr = 1'b0;
        model_reset();

        // Reset held with everything asserted: outputs must stay at zero.
        repeat (3) step();
        chk("reset_cnt", cnt, 64'd0);
        chk("reset_int_st", 64'(int_st), 64'd0);
        chk("reset_tim_int", 64'(tim_int), 64'd0);
        chk("reset_halt_ack", 64'(halt_ack), 64'd0);
        sys_rst_n = 1'b1;
        tim_en = 1'b0; dbg_mode = 1'b0; halt_req = 1'b0; int_en = 1'b0; tcmp = 64'hFF;
        repeat (2) step();

        // ---- divided mode: D = 4, from 5 to 0xFF
        load_cnt(64'd5);
        chk("tdr_load", cnt, 64'd5);
        div_en = 1'b1; div_val = 4'd2; int_en = 1'b1;
        repeat (2) step();
        c0 = cyc; tim_en = 1'b1;
        first_is = -1; first_ti = -1;
        for (int k = 0; k < 1010; k++) begin
            step();
            rel = cyc - c0;
            if (int_st && first_is < 0)  first_is = rel;
            if (tim_int && first_ti < 0) first_ti = rel;
            if (rel == 1000) cnt_a = cnt;
        end
        chk("div_cnt_at_1000", cnt_a, 64'hFF);
        chk("div_int_st_rise", 64'(first_is), 64'd1001);
        chk("div_tim_int_rise", 64'(first_ti), 64'd1002);
        int_en = 1'b0;
        step();
        chk("int_en_off_pin", 64'(tim_int), 64'd0);
        chk("int_en_off_sticky", 64'(int_st), 64'd1);
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        chk("int_clr", 64'(int_st), 64'd0);

        // ---- undivided with a 30-cycle halt window starting at cycle 40
        tim_en = 1'b0;
        step();
        chk("disable_clears", cnt, 64'd0);
        tcmp = 64'd100; div_en = 1'b0; div_val = 4'd0;
        step();
        c0 = cyc; tim_en = 1'b1;
        first_ack = -1;
        for (int k = 0; k < 150; k++) begin
            step();
            rel = cyc - c0;
            if (halt_ack && first_ack < 0) first_ack = rel;
            if (rel == 41) cnt_a = cnt;
            if (rel == 70) cnt_b = cnt;
            if (rel == 72) cnt_c = cnt;
            if (rel == 40) begin halt_req = 1'b1; dbg_mode = 1'b1; end
            if (rel == 70) begin halt_req = 1'b0; dbg_mode = 1'b0; end
        end
        chk("halt_ack_rise", 64'(first_ack), 64'd41);
        chk("halt_frozen_41", cnt_a, 64'd41);
        chk("halt_frozen_70", cnt_b, 64'd41);
        chk("halt_resume", cnt_c, 64'd42);

        // ---- wrap through zero, tcmp = 1
        tim_en = 1'b0;
        step();
        tcmp = 64'd1; int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        load_cnt(64'hFFFF_FFFF_FFFF_FFFE);
        tim_en = 1'b1;
        wc[0] = cnt; wi[0] = int_st;
        for (int k = 1; k < 6; k++) begin
            step();
            wc[k] = cnt; wi[k] = int_st;
        end
        chk("wrap_c0", wc[0], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_c1", wc[1], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wrap_c2", wc[2], 64'd0);
        chk("wrap_c3", wc[3], 64'd1);
        chk("wrap_is3", 64'(wi[3]), 64'd0);
        chk("wrap_is4", 64'(wi[4]), 64'd1);

        // ---- tcmp all ones: match one count before the wrap
        tim_en = 1'b0;
        step();
        tcmp = 64'hFFFF_FFFF_FFFF_FFFF; int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        load_cnt(64'hFFFF_FFFF_FFFF_FFFD);
        tim_en = 1'b1;
        wc[0] = cnt; wi[0] = int_st;
        for (int k = 1; k < 6; k++) begin
            step();
            wc[k] = cnt; wi[k] = int_st;
        end
        chk("max_is0", 64'(wi[0]), 64'd0);
        chk("max_is2", 64'(wi[2]), 64'd0);
        chk("max_is3", 64'(wi[3]), 64'd1);
        chk("max_c3", wc[3], 64'd0);

        // ---- set/clear collision, disable, persistent match
        tim_en = 1'b0;
        step();
        tcmp = 64'h40; int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        load_cnt(64'h3D);
        tim_en = 1'b1;
        repeat (3) step();
        chk("coll_at_match", cnt, 64'h40);
        int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        chk("collision_set_wins", 64'(int_st), 64'd1);
        tim_en = 1'b0;
        step();
        chk("coll_disable_zero", cnt, 64'd0);
        tcmp = 64'd0; int_clr = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("persist_match", 64'(int_st), 64'd1);
        end
        int_clr = 1'b0;

        // ---- divider change mid-count: 8 -> 2 -> 256
        tcmp = 64'hFFFF_0000_0000_0000; int_clr = 1'b1;
        step();
        int_clr = 1'b0;
        div_en = 1'b1; div_val = 4'd3;
        repeat (2) step();
        c0 = cyc; tim_en = 1'b1;
        for (int k = 0; k < 545; k++) begin
            step();
            rel = cyc - c0;
            if (rel == 20)  cnt_a = cnt;
            if (rel == 22)  cnt_b = cnt;
            if (rel == 23)  cnt_c = cnt;
            if (rel == 25)  cnt_d = cnt;
            if (rel == 27)  cnt_e = cnt;
            if (rel == 20)  div_val = 4'd1;
            if (rel == 28)  div_val = 4'd12;
            if (rel == 284) wc[0] = cnt;
            if (rel == 285) wc[1] = cnt;
            if (rel == 541) wc[2] = cnt;
        end
        chk("div8_cnt20", cnt_a, 64'd2);
        chk("div2_cnt22", cnt_b, 64'd2);
        chk("div2_cnt23", cnt_c, 64'd3);
        chk("div2_cnt25", cnt_d, 64'd4);
        chk("div2_cnt27", cnt_e, 64'd5);
        chk("div256_cnt284", wc[0], 64'd5);
        chk("div256_cnt285", wc[1], 64'd6);
        chk("div256_cnt541", wc[2], 64'd7);

        // ---- asynchronous reset while halted with the interrupt up
        halt_req = 1'b1; dbg_mode = 1'b1;
        repeat (2) step();
        tcmp = m_cnt; int_en = 1'b1;
        repeat (3) step();
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_cnt", cnt, 64'd0);
        chk("async_rst_int_st", 64'(int_st), 64'd0);
        chk("async_rst_tim_int", 64'(tim_int), 64'd0);
        chk("async_rst_halt_ack", 64'(halt_ack), 64'd0);
        halt_req = 1'b0; dbg_mode = 1'b0; div_en = 1'b0;
        repeat (2) step();
        sys_rst_n = 1'b1;
        repeat (12) step();

        // ---- randomized traffic against the model
        tim_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step();
            tdr0_wr = ($urandom_range(0, 49) == 0);
            tdr1_wr = ($urandom_range(0, 49) == 0);
            wdata   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            int_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) tim_en   = ~tim_en;
            if ($urandom_range(0, 31) == 0) int_en   = ~int_en;
            if ($urandom_range(0, 39) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 39) == 0) dbg_mode = ~dbg_mode;
            if ($urandom_range(0, 99) == 0) begin
                div_en  = 1'($urandom_range(0, 1));
                div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 39) == 0) tcmp = m_cnt + 64'($urandom_range(0, 20));
        end
        tdr0_wr = 1'b0; tdr1_wr = 1'b0; int_clr = 1'b0;
        repeat (3) step();
        @(negedge sys_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
